fetch_unit: RTL

- IF stage of the 5-stage MIPS pipeline. Sits directly downstream of NPC.
- Owns the F_PC register and issues instruction-memory requests over a req/rvalid handshake.
- Holds the F/D pipeline register and feeds D_PC / D_instr back to NPC and decode.
- Absorbs variable memory latency and data-hazard stalls without losing an instruction or a branch delay slot.

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_hold_buf.sv | 42 ++++
 rtl/fetch_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_pkg
// Brief    : Shared state codes, constants and default addresses for fetch.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

  localparam int FETCH_STATE_SIZE = 2;

  localparam logic [FETCH_STATE_SIZE-1:0] FETCH_IDLE = 2'd0;
  localparam logic [FETCH_STATE_SIZE-1:0] FETCH_REQ  = 2'd1;
  localparam logic [FETCH_STATE_SIZE-1:0] FETCH_HOLD = 2'd2;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_SIZE  = 32'h0000_4000;

endpackage
`default_nettype wire

// File: rtl/fetch_hold_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_hold_buf
// Brief    : One-entry instruction/PC buffer parking a word fetched during a stall.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_unload,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_full
);

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= 32'h0;
      r_pc    <= 32'h0;
      r_full  <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_full  <= 1'b1;
    end else if (i_unload) begin
      r_full  <= 1'b0;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_full  = r_full;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : IF stage - owns F_PC, issues imem requests, holds the F/D register.
//            Optional address-error detection when FETCH_ADEL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
  parameter logic [31:0] IM_SIZE  = DEF_IM_SIZE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_PC,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC,
  output logic [31:0] D_instr,
  output logic        D_valid,
`ifdef FETCH_ADEL_EN
  output logic        D_exc_adel,
`endif
  output logic        fetch_stall
);

  logic [FETCH_STATE_SIZE-1:0] r_state;
  logic [FETCH_STATE_SIZE-1:0] w_next_state;
  logic [31:0] r_f_pc;
  logic [31:0] r_d_pc;
  logic [31:0] r_d_instr;
  logic        r_d_valid;
  logic        w_bad_addr;
  logic        w_deliver;
  logic        w_load_d;
  logic        w_buf_load;
  logic        w_buf_unload;
  logic        w_buf_full;
  logic [31:0] w_buf_instr;
  logic [31:0] w_buf_pc;
  logic [31:0] w_new_instr;

`ifdef FETCH_ADEL_EN
  logic r_d_exc;
  logic r_hold_exc;

  assign w_bad_addr = (r_f_pc[1:0] != 2'b00) || (r_f_pc < IM_BASE) ||
                      (r_f_pc >= (IM_BASE + IM_SIZE));
`else
  logic w_unused_cfg;

  assign w_bad_addr   = 1'b0;
  assign w_unused_cfg = ^{IM_BASE, IM_SIZE};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= FETCH_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FETCH_IDLE: w_next_state = FETCH_REQ;
      FETCH_REQ:  if (w_deliver && stall) w_next_state = FETCH_HOLD;
      FETCH_HOLD: if (!stall) w_next_state = FETCH_REQ;
      default:    w_next_state = FETCH_IDLE;
    endcase
  end

  // A faulting address counts as an instant delivery without touching memory.
  always_comb begin
    imem_req     = 1'b0;
    fetch_stall  = 1'b0;
    w_deliver    = 1'b0;
    w_buf_load   = 1'b0;
    w_buf_unload = 1'b0;
    w_load_d     = 1'b0;
    case (r_state)
      FETCH_REQ: begin
        imem_req    = !w_bad_addr;
        w_deliver   = imem_rvalid || w_bad_addr;
        fetch_stall = !w_deliver;
        w_buf_load  = w_deliver && stall;
        w_load_d    = w_deliver && !stall;
      end
      FETCH_HOLD: begin
        w_buf_unload = !stall && w_buf_full;
        w_load_d     = w_buf_unload;
      end
      default: ;
    endcase
  end

  assign w_new_instr = w_bad_addr ? NOP_INSTR : imem_rdata;

  fetch_hold_buf u_hold_buf (
    .clk      (clk),
    .rst_n    (reset),
    .i_load   (w_buf_load),
    .i_unload (w_buf_unload),
    .i_instr  (w_new_instr),
    .i_pc     (r_f_pc),
    .o_instr  (w_buf_instr),
    .o_pc     (w_buf_pc),
    .o_full   (w_buf_full)
  );

  // next_PC is only sampled on the edge that loads D (delay-slot semantics).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_f_pc    <= RESET_PC;
      r_d_pc    <= 32'h0;
      r_d_instr <= NOP_INSTR;
      r_d_valid <= 1'b0;
    end else if (w_load_d) begin
      r_d_pc    <= w_buf_unload ? w_buf_pc : r_f_pc;
      r_d_instr <= w_buf_unload ? w_buf_instr : w_new_instr;
      r_d_valid <= 1'b1;
      r_f_pc    <= next_PC;
    end
  end

`ifdef FETCH_ADEL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d_exc    <= 1'b0;
      r_hold_exc <= 1'b0;
    end else begin
      if (w_buf_load) r_hold_exc <= w_bad_addr;
      if (w_load_d)   r_d_exc    <= w_buf_unload ? r_hold_exc : w_bad_addr;
    end
  end

  assign D_exc_adel = r_d_exc;
`endif

  assign imem_addr = r_f_pc;
  assign F_PC      = r_f_pc;
  assign D_PC      = r_d_pc;
  assign D_instr   = r_d_instr;
  assign D_valid   = r_d_valid;

endmodule
`default_nettype wire
